// File: rtl/sap_datapath_if.sv
// Control-word, program-load and observation signals between the
// SAP control unit (master) and the datapath (slave).
interface sap_datapath_if;
   logic [13:0] cs;
   logic [5:0]  bus_cs;
   logic        prog_we;
   logic [7:0]  prog_addr;
   logic [15:0] prog_data;
   logic [7:0]  opcode;
   logic [1:0]  flag;
   logic [15:0] out_data;
   logic        out_valid;
   logic        bus_err;
   logic [15:0] dbg_bus;

   modport master (
      output cs, bus_cs, prog_we, prog_addr, prog_data,
      input  opcode, flag, out_data, out_valid, bus_err, dbg_bus
   );

   modport slave (
      input  cs, bus_cs, prog_we, prog_addr, prog_data,
      output opcode, flag, out_data, out_valid, bus_err, dbg_bus
   );
endinterface

// File: rtl/sap_datapath.sv
// 16-bit SAP datapath: ACC/B/MAR/PC/IR/flags/OUT and a 256x16 RAM
// sharing one internal bus, steered by the control unit's cs words.
module sap_datapath #(
   parameter int RAM_DEPTH = 256
) (
   input  logic          clk,
   input  logic          rst,
   sap_datapath_if.slave dp
);

   logic       acc_we, accl_we, b_we, flag_we, ir_we;
   logic       mar_we, out_we, pc_inc, pc_we, ram_we;
   logic [3:0] alu_op;

   assign {acc_we, accl_we, alu_op, b_we, flag_we, ir_we,
           mar_we, out_we, pc_inc, pc_we, ram_we} = dp.cs;

   logic [15:0] acc_q, b_q, ir_q, out_q;
   logic [7:0]  mar_q, pc_q;
   logic [1:0]  flag_q;
   logic        out_valid_q, bus_err_q;

   logic [15:0] mem [RAM_DEPTH];
   logic [15:0] ram_rd;
   logic [15:0] bus, bus_fwd, b_eff;
   logic [16:0] alu_full;
   logic [15:0] alu_r;
   logic        alu_c, alu_z, multi_drv;

   assign ram_rd = mem[mar_q];

   always_comb begin
      bus = 16'h0000;
      priority case (1'b1)
         dp.bus_cs[5]: bus = acc_q;
         dp.bus_cs[4]: bus = alu_r;
         dp.bus_cs[3]: bus = {8'h00, ir_q[7:0]};
         dp.bus_cs[2]: bus = {8'h00, mar_q};
         dp.bus_cs[1]: bus = {8'h00, pc_q};
         dp.bus_cs[0]: bus = ram_rd;
         default:      bus = 16'h0000;
      endcase
   end

   // Forwarded B operand: when the ALU itself wins the bus, B keeps its
   // stored value so the ALU never sees its own output.
   always_comb begin
      bus_fwd = 16'h0000;
      priority case (1'b1)
         dp.bus_cs[5]: bus_fwd = acc_q;
         dp.bus_cs[4]: bus_fwd = b_q;
         dp.bus_cs[3]: bus_fwd = {8'h00, ir_q[7:0]};
         dp.bus_cs[2]: bus_fwd = {8'h00, mar_q};
         dp.bus_cs[1]: bus_fwd = {8'h00, pc_q};
         dp.bus_cs[0]: bus_fwd = ram_rd;
         default:      bus_fwd = 16'h0000;
      endcase
   end

   assign b_eff = b_we ? bus_fwd : b_q;

   always_comb begin
      alu_full = 17'h0_0000;
      unique case (alu_op)
         4'd0:    alu_full = {1'b0, acc_q} + {1'b0, b_eff};
         4'd1:    alu_full = {acc_q < b_eff, acc_q - b_eff};
         4'd2:    alu_full = {acc_q == 16'hFFFF, acc_q + 16'd1};
         4'd3:    alu_full = {acc_q == 16'h0000, acc_q - 16'd1};
         4'd4:    alu_full = {1'b0, acc_q & b_eff};
         4'd5:    alu_full = {1'b0, acc_q | b_eff};
         4'd6:    alu_full = {1'b0, acc_q ^ b_eff};
         4'd7:    alu_full = {1'b0, ~acc_q};
         default: alu_full = 17'h0_0000;
      endcase
   end

   assign alu_r = alu_full[15:0];
   assign alu_c = alu_full[16];
   assign alu_z = (alu_r == 16'h0000);

   assign multi_drv = |(dp.bus_cs & (dp.bus_cs - 6'd1));

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q       <= '0;
         b_q         <= '0;
         mar_q       <= '0;
         pc_q        <= '0;
         ir_q        <= '0;
         out_q       <= '0;
         flag_q      <= '0;
         out_valid_q <= 1'b0;
         bus_err_q   <= 1'b0;
      end else begin
         if (acc_we)       acc_q <= bus;
         else if (accl_we) acc_q <= {8'h00, bus[7:0]};
         if (b_we)   b_q   <= bus;
         if (mar_we) mar_q <= bus[7:0];
         if (ir_we)  ir_q  <= bus;
         if (pc_we)       pc_q <= bus[7:0];
         else if (pc_inc) pc_q <= pc_q + 8'd1;
         if (flag_we) flag_q <= {alu_c, alu_z};
         if (out_we)  out_q  <= bus;
         out_valid_q <= out_we;
         if (multi_drv) bus_err_q <= 1'b1;
      end
   end

   // RAM survives reset; reset is the only window for program loading.
   always_ff @(posedge clk) begin
      if (rst) begin
         if (dp.prog_we) mem[dp.prog_addr] <= dp.prog_data;
      end else if (ram_we) begin
         mem[mar_q] <= bus;
      end
   end

   assign dp.opcode    = ir_q[15:8];
   assign dp.flag      = flag_q;
   assign dp.out_data  = out_q;
   assign dp.out_valid = out_valid_q;
   assign dp.bus_err   = bus_err_q;
   assign dp.dbg_bus   = bus;

endmodule

// File: tb/tb_sap_datapath.sv
// Scoreboard bench for sap_datapath: directed CU micro-sequences push
// expected values; a negedge monitor pops and compares them.
module tb_sap_datapath;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   sap_datapath_if dp ();

   sap_datapath #(.RAM_DEPTH(256)) u_dut (
      .clk (clk),
      .rst (rst),
      .dp  (dp)
   );

   localparam logic [13:0] C_ACCW  = 14'h2000;
   localparam logic [13:0] C_BW    = 14'h0080;
   localparam logic [13:0] C_FW    = 14'h0040;
   localparam logic [13:0] C_IRW   = 14'h0020;
   localparam logic [13:0] C_MARW  = 14'h0010;
   localparam logic [13:0] C_OUTW  = 14'h0008;
   localparam logic [13:0] C_PCINC = 14'h0004;
   localparam logic [13:0] C_PCW   = 14'h0002;
   localparam logic [13:0] C_RAMW  = 14'h0001;

   localparam logic [5:0] S_ACC = 6'h20;
   localparam logic [5:0] S_ALU = 6'h10;
   localparam logic [5:0] S_IR  = 6'h08;
   localparam logic [5:0] S_MAR = 6'h04;
   localparam logic [5:0] S_PC  = 6'h02;
   localparam logic [5:0] S_RAM = 6'h01;

   localparam int P_BUS = 0;
   localparam int P_OPC = 1;
   localparam int P_FLG = 2;
   localparam int P_OV  = 4;
   localparam int P_ERR = 5;

   typedef struct {
      int          cyc;
      int          sel;
      logic [15:0] val;
      string       name;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] out_sb[$];
   int cyc_cnt = 0;
   int n_run   = 0;
   int n_fail  = 0;
   int n_pulse = 0;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   function automatic logic [15:0] probe(int sel);
      case (sel)
         P_BUS:   return dp.dbg_bus;
         P_OPC:   return {8'h00, dp.opcode};
         P_FLG:   return {14'h0000, dp.flag};
         P_OV:    return {15'h0000, dp.out_valid};
         P_ERR:   return {15'h0000, dp.bus_err};
         default: return dp.out_data;
      endcase
   endfunction

   task automatic check(string name, logic [15:0] act, logic [15:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      int i;
      i = 0;
      while (i < sb.size()) begin
         if (sb[i].cyc == cyc_cnt) begin
            check(sb[i].name, probe(sb[i].sel), sb[i].val);
            sb.delete(i);
         end else if (sb[i].cyc < cyc_cnt) begin
            n_run++;
            n_fail++;
            $display("FAIL %s: never sampled, expected %h",
                     sb[i].name, sb[i].val);
            sb.delete(i);
         end else begin
            i++;
         end
      end
      if (dp.out_valid === 1'b1) begin
         n_pulse++;
         if (out_sb.size() == 0) begin
            n_run++;
            n_fail++;
            $display("FAIL out_unexpected: got %h, expected no pulse",
                     dp.out_data);
         end else begin
            check("out_data", dp.out_data, out_sb.pop_front());
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(logic [13:0] c, logic [5:0] b);
      dp.cs     = c;
      dp.bus_cs = b;
   endtask

   task automatic now(int sel, logic [15:0] v, string n);
      sb.push_back('{cyc_cnt, sel, v, n});
   endtask

   task automatic nxt(int sel, logic [15:0] v, string n);
      sb.push_back('{cyc_cnt + 1, sel, v, n});
   endtask

   task automatic prog(logic [7:0] a, logic [15:0] d);
      dp.prog_we   = 1'b1;
      dp.prog_addr = a;
      dp.prog_data = d;
      tick();
      dp.prog_we   = 1'b0;
   endtask

   // MAR <- low byte of mem[PC], PC++ (operand-pointer fetch)
   task automatic ptr;
      drive(C_MARW, S_PC);
      tick();
      drive(C_IRW | C_PCINC, S_RAM);
      tick();
      drive(C_MARW, S_IR);
      tick();
   endtask

   function automatic logic [13:0] op(int n);
      return 14'(n) << 8;
   endfunction

   initial begin
      rst          = 1'b1;
      dp.prog_we   = 1'b0;
      dp.prog_addr = '0;
      dp.prog_data = '0;
      drive('0, '0);
      tick();

      prog(8'h00, 16'h0A34);
      prog(8'h01, 16'h0B00);
      prog(8'h02, 16'h0C00);
      prog(8'h03, 16'h0040);
      prog(8'h04, 16'h0041);
      prog(8'h05, 16'h0043);
      prog(8'h06, 16'h0044);
      prog(8'h07, 16'h0045);
      prog(8'h08, 16'h0045);
      prog(8'h09, 16'h0042);
      prog(8'h40, 16'hFFFF);
      prog(8'h41, 16'h0001);
      prog(8'h42, 16'h00FF);
      prog(8'h43, 16'h0003);
      prog(8'h44, 16'h0005);
      prog(8'h45, 16'h1234);

      drive(C_ACCW | C_IRW | C_MARW, S_RAM);
      now(P_OPC, 16'h0000, "rst_opcode");
      now(P_FLG, 16'h0000, "rst_flag");
      now(P_OV,  16'h0000, "rst_out_valid");
      now(P_ERR, 16'h0000, "rst_bus_err");
      nxt(P_OPC, 16'h0000, "rst_ignores_ir_write");
      tick();
      drive('0, S_ACC);
      now(P_BUS, 16'h0000, "rst_ignores_acc_write");
      tick();

      rst = 1'b0;
      drive(C_MARW, S_PC);
      now(P_BUS, 16'h0000, "fetch0_pc");
      tick();
      drive(C_IRW | C_PCINC, S_RAM);
      now(P_BUS, 16'h0A34, "fetch0_ram");
      nxt(P_OPC, 16'h000A, "opcode_ldi");
      tick();
      drive(C_ACCW, S_IR);
      now(P_BUS, 16'h0034, "ldi_imm");
      tick();
      drive(C_MARW, S_PC);
      now(P_BUS, 16'h0001, "fetch1_pc");
      tick();
      drive(C_IRW | C_PCINC, S_RAM);
      tick();
      drive(C_OUTW, S_ACC);
      out_sb.push_back(16'h0034);
      nxt(P_OV, 16'h0001, "out_valid_high");
      tick();
      drive(C_MARW, S_PC);
      nxt(P_OV, 16'h0000, "out_valid_single");
      tick();
      drive(C_IRW | C_PCINC, S_RAM);
      nxt(P_OPC, 16'h000C, "opcode_hlt");
      tick();
      drive('0, '0);
      now(P_OPC, 16'h000C, "opcode_hold");
      tick();

      ptr();
      drive(C_ACCW, S_RAM);
      now(P_BUS, 16'hFFFF, "ld_ffff");
      tick();
      ptr();
      drive(C_BW | C_FW | op(0), S_RAM);
      now(P_BUS, 16'h0001, "ld_b_0001");
      nxt(P_FLG, 16'h0003, "add_flags_cz");
      tick();
      drive(C_ACCW | op(0), S_ALU);
      now(P_BUS, 16'h0000, "add_result");
      tick();
      drive('0, S_ACC);
      now(P_BUS, 16'h0000, "acc_after_add");
      tick();

      ptr();
      drive(C_ACCW, S_RAM);
      tick();
      ptr();
      drive(C_BW | C_FW | op(1), S_RAM);
      nxt(P_FLG, 16'h0002, "sub_borrow_flags");
      tick();
      drive(C_ACCW | op(1), S_ALU);
      now(P_BUS, 16'hFFFE, "sub_result");
      tick();
      drive('0, S_ACC);
      now(P_BUS, 16'hFFFE, "acc_after_sub");
      tick();

      ptr();
      drive(C_ACCW, S_RAM);
      tick();
      ptr();
      drive(C_BW | C_FW | op(1), S_RAM);
      nxt(P_FLG, 16'h0001, "sub_zero_flags");
      tick();

      drive(C_FW | op(4), S_ALU);
      now(P_BUS, 16'h1234, "and");
      nxt(P_FLG, 16'h0000, "and_flags");
      tick();
      drive(C_FW | op(6), S_ALU);
      now(P_BUS, 16'h0000, "xor");
      nxt(P_FLG, 16'h0001, "xor_flags");
      tick();
      drive(op(7), S_ALU);
      now(P_BUS, 16'hEDCB, "not");
      tick();
      drive(op(3), S_ALU);
      now(P_BUS, 16'h1233, "dec");
      tick();
      drive(op(2), S_ALU);
      now(P_BUS, 16'h1235, "inc");
      tick();
      drive(op(9), S_ALU);
      now(P_BUS, 16'h0000, "op_reserved");
      tick();
      drive(op(5), S_ALU);
      now(P_BUS, 16'h1234, "or");
      now(P_FLG, 16'h0001, "flags_held");
      tick();

      ptr();
      drive(C_PCW, S_RAM);
      tick();
      drive(C_PCINC, S_PC);
      now(P_BUS, 16'h00FF, "pc_ff");
      tick();
      drive('0, S_PC);
      now(P_BUS, 16'h0000, "pc_wrap");
      tick();
      drive(C_PCW | C_PCINC, S_IR);
      now(P_BUS, 16'h0042, "pcw_bus");
      tick();
      drive('0, S_PC);
      now(P_BUS, 16'h0042, "pcw_wins");
      tick();

      drive('0, S_PC | S_RAM);
      now(P_BUS, 16'h0042, "bus_priority");
      now(P_ERR, 16'h0000, "bus_err_before_edge");
      tick();
      drive('0, '0);
      now(P_ERR, 16'h0001, "bus_err_set");
      now(P_BUS, 16'h0000, "bus_idle");
      tick();
      drive('0, '0);
      now(P_ERR, 16'h0001, "bus_err_sticky");
      tick();

      rst = 1'b1;
      drive(C_RAMW | C_ACCW, S_ACC);
      tick();
      drive('0, S_ACC);
      now(P_BUS, 16'h0000, "rst_acc");
      now(P_OPC, 16'h0000, "rst2_opcode");
      now(P_FLG, 16'h0000, "rst2_flag");
      now(P_ERR, 16'h0000, "rst2_bus_err");
      prog(8'h00, 16'h0042);
      drive('0, S_MAR);
      now(P_BUS, 16'h0000, "rst_mar");
      tick();

      rst = 1'b0;
      drive(C_MARW, S_RAM);
      now(P_BUS, 16'h0042, "prog_during_rst");
      tick();
      drive('0, S_RAM);
      now(P_BUS, 16'h00FF, "ram_write_suppressed");
      dp.prog_we   = 1'b1;
      dp.prog_addr = 8'h42;
      dp.prog_data = 16'hDEAD;
      tick();
      dp.prog_we = 1'b0;
      drive('0, S_RAM);
      now(P_BUS, 16'h00FF, "prog_ignored_run");
      now(P_ERR, 16'h0000, "bus_err_after_rst");
      tick();
      drive('0, '0);
      tick();
      tick();

      check("out_queue_left", 16'(out_sb.size()), 16'h0000);
      check("sb_queue_left", 16'(sb.size()), 16'h0000);
      check("out_pulses", 16'(n_pulse), 16'h0001);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
